// File: rtl/alu_exec_unit.sv
// Two-stage integer ALU execute unit: S1 holds the issued payload, S2 holds the result
// until the writeback port grants it. Younger-than-branch entries are squashed on mispredict.
module alu_exec_unit #(
  parameter int ROB_W  = 5,
  parameter int PREG_W = 7,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              fu_ready,
  input  logic [3:0]        issue_op,
  input  logic [XLEN-1:0]   issue_src1,
  input  logic [XLEN-1:0]   issue_src2,
  input  logic [XLEN-1:0]   issue_imm,
  input  logic              issue_use_imm,
  input  logic [XLEN-1:0]   issue_pc,
  input  logic [ROB_W-1:0]  issue_rob_tag,
  input  logic [PREG_W-1:0] issue_pd,
  input  logic [ROB_W-1:0]  rob_head,
  input  logic              mispredict,
  input  logic [ROB_W-1:0]  mispredict_tag,
  input  logic              wb_grant,
  output logic              fu_alu_done,
  output logic [ROB_W-1:0]  rob_fu_alu,
  output logic [PREG_W-1:0] p_alu_out,
  output logic [XLEN-1:0]   data_alu_out
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_LUI   = 4'd10;
  localparam logic [3:0] OP_AUIPC = 4'd11;

  logic              s1_valid_q, s1_valid_d;
  logic [3:0]        s1_op_q;
  logic [XLEN-1:0]   s1_a_q, s1_b_q, s1_imm_q, s1_pc_q;
  logic [ROB_W-1:0]  s1_tag_q;
  logic [PREG_W-1:0] s1_pd_q;

  logic              s2_valid_q, s2_valid_d;
  logic [ROB_W-1:0]  s2_tag_q;
  logic [PREG_W-1:0] s2_pd_q;
  logic [XLEN-1:0]   s2_data_q;

  logic              s2_free, fire, s1_load, s2_load;
  logic              kill_issue, kill_s1, kill_s2;
  logic [4:0]        shamt;
  logic [XLEN-1:0]   result;

  // Age is the distance from the ROB head, so it stays correct across tag wrap-around.
  function automatic logic [ROB_W-1:0] age(input logic [ROB_W-1:0] t, input logic [ROB_W-1:0] h);
    return t - h;
  endfunction

  assign kill_issue = mispredict && (age(issue_rob_tag, rob_head) > age(mispredict_tag, rob_head));
  assign kill_s1    = mispredict && s1_valid_q && (age(s1_tag_q, rob_head) > age(mispredict_tag, rob_head));
  assign kill_s2    = mispredict && s2_valid_q && (age(s2_tag_q, rob_head) > age(mispredict_tag, rob_head));

  assign s2_free  = !s2_valid_q || wb_grant;
  assign fu_ready = !s1_valid_q || s2_free;
  assign fire     = issue_valid && fu_ready;
  assign shamt    = s1_b_q[4:0];

  always_comb begin
    result = '0;
    case (s1_op_q)
      OP_ADD:   result = s1_a_q + s1_b_q;
      OP_SUB:   result = s1_a_q - s1_b_q;
      OP_SLL:   result = s1_a_q << shamt;
      OP_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      OP_SLTU:  result = {{(XLEN-1){1'b0}}, (s1_a_q < s1_b_q)};
      OP_XOR:   result = s1_a_q ^ s1_b_q;
      OP_SRL:   result = s1_a_q >> shamt;
      OP_SRA:   result = $signed(s1_a_q) >>> shamt;
      OP_OR:    result = s1_a_q | s1_b_q;
      OP_AND:   result = s1_a_q & s1_b_q;
      OP_LUI:   result = s1_b_q;
      OP_AUIPC: result = s1_pc_q + s1_imm_q;
      default:  result = '0;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s2_load    = 1'b0;
    s1_load    = fire && !kill_issue;
    // A firing issue always finds S1 empty or vacating, so it simply replaces it.
    if (fire)
      s1_valid_d = !kill_issue;
    else if (s2_free || kill_s1)
      s1_valid_d = 1'b0;
    if (s1_valid_q && s2_free) begin
      s2_load    = !kill_s1;
      s2_valid_d = !kill_s1;
    end else if (wb_grant || kill_s2) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_imm_q   <= '0;
      s1_pc_q    <= '0;
      s1_tag_q   <= '0;
      s1_pd_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= '0;
      s2_pd_q    <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) begin
        s1_op_q  <= issue_op;
        s1_a_q   <= issue_src1;
        s1_b_q   <= issue_use_imm ? issue_imm : issue_src2;
        s1_imm_q <= issue_imm;
        s1_pc_q  <= issue_pc;
        s1_tag_q <= issue_rob_tag;
        s1_pd_q  <= issue_pd;
      end
      if (s2_load) begin
        s2_tag_q  <= s1_tag_q;
        s2_pd_q   <= s1_pd_q;
        s2_data_q <= (s1_pd_q == '0) ? '0 : result;
      end
    end
  end

  assign fu_alu_done  = s2_valid_q;
  assign rob_fu_alu   = s2_tag_q;
  assign p_alu_out    = s2_pd_q;
  assign data_alu_out = s2_data_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, hand-built stall/flush/reset sequences and
// randomized traffic, all checked against an in-order scoreboard of expected completions.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, fu_ready, issue_use_imm;
  logic [3:0]  issue_op;
  logic [31:0] issue_src1, issue_src2, issue_imm, issue_pc;
  logic [4:0]  issue_rob_tag, rob_head, mispredict_tag, rob_fu_alu;
  logic [6:0]  issue_pd, p_alu_out;
  logic        mispredict, wb_grant, fu_alu_done;
  logic [31:0] data_alu_out;

  alu_exec_unit dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .fu_ready(fu_ready),
    .issue_op(issue_op), .issue_src1(issue_src1), .issue_src2(issue_src2),
    .issue_imm(issue_imm), .issue_use_imm(issue_use_imm), .issue_pc(issue_pc),
    .issue_rob_tag(issue_rob_tag), .issue_pd(issue_pd), .rob_head(rob_head),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag), .wb_grant(wb_grant),
    .fu_alu_done(fu_alu_done), .rob_fu_alu(rob_fu_alu), .p_alu_out(p_alu_out),
    .data_alu_out(data_alu_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  tag;
    logic [6:0]  pd;
    logic [31:0] data;
    int          earliest;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, imm, pc;
    logic        ub;
    logic [4:0]  tag;
    logic [6:0]  pd;
    logic [31:0] exp;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[14];
  logic [31:0] drv_exp;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm,
                                          input logic [31:0] pc);
    int s;
    s = int'(b[4:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << s;
      4'd3:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> s;
      4'd7:  return (a >> s) | ((a >= 32'h8000_0000) ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      4'd11: return pc + imm;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit killed(input logic [4:0] t);
    int at, am;
    at = (int'(t) - int'(rob_head) + 32) % 32;
    am = (int'(mispredict_tag) - int'(rob_head) + 32) % 32;
    return at > am;
  endfunction

  task automatic set_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [31:0] pc, input logic ub,
                           input logic [4:0] tag, input logic [6:0] pd);
    issue_valid = 1'b1; issue_op = op; issue_src1 = a; issue_src2 = b; issue_imm = imm;
    issue_pc = pc; issue_use_imm = ub; issue_rob_tag = tag; issue_pd = pd;
    drv_exp = ref_alu(op, a, ub ? imm : b, imm, pc);
  endtask

  // One clock of traffic: inputs are already driven; sample, check, update the scoreboard.
  task automatic step();
    bit   exp_done, exp_rdy, fire, lost;
    exp_t e;
    #1;
    exp_rdy  = (sb.size() < 2) || wb_grant;
    exp_done = (sb.size() > 0) && (sb[0].earliest <= cyc);
    chk("fu_ready", 32'(fu_ready), 32'(exp_rdy));
    chk("done", 32'(fu_alu_done), 32'(exp_done));
    if (exp_done && fu_alu_done) begin
      chk("rob_tag", 32'(rob_fu_alu), 32'(sb[0].tag));
      chk("preg", 32'(p_alu_out), 32'(sb[0].pd));
      chk("data", data_alu_out, sb[0].data);
    end
    fire = issue_valid && fu_ready;
    lost = 1'b0;
    if (exp_done && wb_grant)
      void'(sb.pop_front());
    else if (exp_done && mispredict && killed(sb[0].tag))
      lost = 1'b1;
    if (mispredict)
      for (int i = sb.size() - 1; i >= 0; i--)
        if (killed(sb[i].tag)) sb.delete(i);
    if (lost && sb.size() > 0 && sb[0].earliest < cyc + 2)
      sb[0].earliest = cyc + 2;
    if (fire && !(mispredict && killed(issue_rob_tag))) begin
      e.tag = issue_rob_tag;
      e.pd = issue_pd;
      e.data = (issue_pd == 7'd0) ? 32'd0 : drv_exp;
      e.earliest = cyc + 2;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic g);
    issue_valid = 1'b0; mispredict = 1'b0; wb_grant = g;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    vt[0]  = '{4'd0,  32'd5,          32'd7,          32'd0,          32'd0,      1'b0, 5'd3,  7'd40, 32'd12};
    vt[1]  = '{4'd7,  32'h8000_0000,  32'd0,          32'd4,          32'd0,      1'b1, 5'd4,  7'd41, 32'hF800_0000};
    vt[2]  = '{4'd4,  32'd1,          32'hFFFF_FFFF,  32'd0,          32'd0,      1'b0, 5'd5,  7'd42, 32'd1};
    vt[3]  = '{4'd1,  32'd3,          32'd5,          32'd0,          32'd0,      1'b0, 5'd6,  7'd43, 32'hFFFF_FFFE};
    vt[4]  = '{4'd3,  32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0,      1'b0, 5'd7,  7'd44, 32'd1};
    vt[5]  = '{4'd2,  32'd1,          32'd31,         32'd0,          32'd0,      1'b0, 5'd8,  7'd45, 32'h8000_0000};
    vt[6]  = '{4'd6,  32'h8000_0000,  32'd4,          32'd0,          32'd0,      1'b0, 5'd9,  7'd46, 32'h0800_0000};
    vt[7]  = '{4'd10, 32'd99,         32'd0,          32'h1234_5000,  32'd0,      1'b1, 5'd10, 7'd47, 32'h1234_5000};
    vt[8]  = '{4'd11, 32'd0,          32'd0,          32'h2000,       32'h1000,   1'b1, 5'd11, 7'd0,  32'd0};
    vt[9]  = '{4'd11, 32'd0,          32'd0,          32'h2000,       32'h1000,   1'b1, 5'd12, 7'd5,  32'h3000};
    vt[10] = '{4'd5,  32'hF0F0,       32'hFF00,       32'd0,          32'd0,      1'b0, 5'd13, 7'd48, 32'h0FF0};
    vt[11] = '{4'd8,  32'hF0F0,       32'hFF00,       32'd0,          32'd0,      1'b0, 5'd14, 7'd49, 32'hFFF0};
    vt[12] = '{4'd13, 32'd5,          32'd5,          32'd0,          32'd0,      1'b0, 5'd15, 7'd50, 32'd0};
    vt[13] = '{4'd2,  32'd1,          32'd33,         32'd0,          32'd0,      1'b0, 5'd16, 7'd51, 32'd2};

    reset = 1'b1; issue_valid = 1'b0; issue_op = '0; issue_src1 = '0; issue_src2 = '0;
    issue_imm = '0; issue_use_imm = 1'b0; issue_pc = '0; issue_rob_tag = '0; issue_pd = '0;
    rob_head = '0; mispredict = 1'b0; mispredict_tag = '0; wb_grant = 1'b1; drv_exp = '0;
    #3;
    chk("rst_done", 32'(fu_alu_done), 32'd0);
    chk("rst_ready", 32'(fu_ready), 32'd1);
    chk("rst_data", data_alu_out, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Directed vectors, issued back to back with the writeback port always granting.
    for (int i = 0; i < 14; i++) begin
      set_issue(vt[i].op, vt[i].a, vt[i].b, vt[i].imm, vt[i].pc, vt[i].ub, vt[i].tag, vt[i].pd);
      drv_exp = vt[i].exp;
      wb_grant = 1'b1; mispredict = 1'b0;
      step();
    end
    idle(4, 1'b1);

    // Back-pressure: two in flight, grant withheld for three cycles, third op offered.
    wb_grant = 1'b0; mispredict = 1'b0;
    set_issue(4'd0, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 5'd20, 7'd9);  step();
    set_issue(4'd9, 32'hFF, 32'h0F, 32'd0, 32'd0, 1'b0, 5'd21, 7'd10); step();
    set_issue(4'd5, 32'h3, 32'h1, 32'd0, 32'd0, 1'b0, 5'd22, 7'd11); step(); step(); step();
    idle(4, 1'b1);

    // Flush across tag wrap: head 30, S2 tag 31 survives, S1 tag 1 is killed.
    rob_head = 5'd30; mispredict_tag = 5'd0; wb_grant = 1'b1; mispredict = 1'b0;
    set_issue(4'd0, 32'd2, 32'd3, 32'd0, 32'd0, 1'b0, 5'd31, 7'd12); step();
    set_issue(4'd0, 32'd4, 32'd5, 32'd0, 32'd0, 1'b0, 5'd1, 7'd13);  step();
    issue_valid = 1'b0; wb_grant = 1'b0; mispredict = 1'b1; step();
    idle(3, 1'b1);

    // Flush with grant on a killed S2 entry, and a killed issue firing in the same cycle.
    rob_head = 5'd0; mispredict_tag = 5'd5;
    set_issue(4'd0, 32'd6, 32'd7, 32'd0, 32'd0, 1'b0, 5'd10, 7'd14); step();
    issue_valid = 1'b0; step();
    set_issue(4'd1, 32'd9, 32'd1, 32'd0, 32'd0, 1'b0, 5'd20, 7'd15);
    mispredict = 1'b1; wb_grant = 1'b1; step();
    idle(3, 1'b1);

    // Killed S2 without grant while an older S1 entry survives and must move up later.
    wb_grant = 1'b0;
    set_issue(4'd0, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 5'd9, 7'd16); step();
    set_issue(4'd0, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 5'd2, 7'd17); step();
    issue_valid = 1'b0; mispredict = 1'b1; step();
    idle(4, 1'b1);

    // Randomized traffic with occasional back-pressure and flushes.
    for (int i = 0; i < 600; i++) begin
      set_issue(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127)));
      issue_valid = ($urandom_range(0, 3) != 0);
      wb_grant = ($urandom_range(0, 3) != 0);
      rob_head = 5'($urandom_range(0, 31));
      mispredict_tag = 5'($urandom_range(0, 31));
      mispredict = ($urandom_range(0, 15) == 0);
      step();
    end
    idle(4, 1'b1);

    // Reset with both stages full and done stalled.
    wb_grant = 1'b0; mispredict = 1'b0;
    set_issue(4'd0, 32'd8, 32'd8, 32'd0, 32'd0, 1'b0, 5'd3, 7'd20); step();
    set_issue(4'd1, 32'd8, 32'd1, 32'd0, 32'd0, 1'b0, 5'd4, 7'd21); step();
    issue_valid = 1'b0; step();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_done", 32'(fu_alu_done), 32'd0);
    chk("mid_rst_tag", 32'(rob_fu_alu), 32'd0);
    chk("mid_rst_preg", 32'(p_alu_out), 32'd0);
    chk("mid_rst_data", data_alu_out, 32'd0);
    chk("mid_rst_ready", 32'(fu_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    idle(5, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
